sound_mixer_mc: RTL and testbench



---
 rtl/sound_pkg.sv | 20 ++
 rtl/sound_mixer_regs.sv | 91 +++++++++
 rtl/sound_mixer_mc.sv | 150 +++++++++++++++
 tb/tb_sound_mixer_mc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the multi-channel sound mixer: register indices,
// volume defaults and the mix sequencer states.
package sound_pkg;

  localparam logic [7:0] MIX_IDX_RESET   = 8'h00;
  localparam logic [7:0] MIX_IDX_MASTER  = 8'h22;
  localparam logic [7:0] MIX_IDX_CH_BASE = 8'h30;
  localparam logic [7:0] MIX_IDX_STATUS  = 8'h3F;

  // Full volume on both sides (L in [7:4], R in [3:0]).
  localparam logic [7:0] MIX_VOL_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_MASTER,
    ST_SAT
  } mix_state_t;

endpackage

// File: rtl/sound_mixer_regs.sv
// Sound Blaster Pro style index/data register pair for the mixer: per-channel
// and master volumes, sticky status bits and the combinational read mux.
module sound_mixer_regs
  import sound_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  io_address,
  input  logic                  io_read,
  input  logic                  io_write,
  input  logic [7:0]            io_writedata,
  output logic [7:0]            io_readdata,
  output logic [CHANNELS*8-1:0] ch_vol,
  output logic [7:0]            master_vol,
  input  logic                  set_clip_l,
  input  logic                  set_clip_r,
  input  logic                  set_overrun
);

  logic [7:0] index_q;
  logic [7:0] master_q;
  logic [7:0] vol_q [CHANNELS];
  logic [2:0] status_q;
  logic [2:0] status_next;
  logic       status_clr;

  // A data read of the status index or a write to the reset index clears status.
  assign status_clr = io_address &&
                      ((io_read  && index_q == MIX_IDX_STATUS) ||
                       (io_write && index_q == MIX_IDX_RESET));

  // Sticky status: hardware sets win over a same-cycle clear.
  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    status_next = status_q;
    if (status_clr) status_next = '0;
    status_next = status_next | {set_overrun, set_clip_r, set_clip_l};
  end

  // Index register, volume registers and status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q  <= MIX_IDX_RESET;
      master_q <= MIX_VOL_DEFAULT;
      for (int c = 0; c < CHANNELS; c++) vol_q[c] <= MIX_VOL_DEFAULT;
      status_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (io_write && !io_address) index_q <= io_writedata;
      if (io_write && io_address) begin
        if (index_q == MIX_IDX_RESET) begin
          master_q <= MIX_VOL_DEFAULT;
          for (int c = 0; c < CHANNELS; c++) vol_q[c] <= MIX_VOL_DEFAULT;
        end else if (index_q == MIX_IDX_MASTER) begin
          master_q <= io_writedata;
        end else begin
          for (int c = 0; c < CHANNELS; c++)
            if (index_q == MIX_IDX_CH_BASE + 8'(c)) vol_q[c] <= io_writedata;
        end
      end
      status_q <= status_next;
    end
  end

  // Combinational read mux; unmapped indices read as 0xFF.
  always_comb begin
    io_readdata = 8'hFF;
    if (!io_address) begin
      io_readdata = index_q;
    end else if (index_q == MIX_IDX_RESET) begin
      io_readdata = 8'h00;
    end else if (index_q == MIX_IDX_MASTER) begin
      io_readdata = master_q;
    end else if (index_q == MIX_IDX_STATUS) begin
      io_readdata = {5'b0, status_q};
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        if (index_q == MIX_IDX_CH_BASE + 8'(c)) io_readdata = vol_q[c];
    end
  end

  assign master_vol = master_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_vol
    assign ch_vol[g*8 +: 8] = vol_q[g];
  end

endmodule

// File: rtl/sound_mixer_mc.sv
// Multi-channel stereo mixer: snapshots all sources on sample_tick, then
// accumulates one channel per clock, applies master volume and saturates.
module sound_mixer_mc
  import sound_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SAMPLE_W = 16,
  parameter int OUT_W    = 16,
  parameter int VOL_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         io_address,
  input  logic                         io_read,
  input  logic                         io_write,
  input  logic [7:0]                   io_writedata,
  output logic [7:0]                   io_readdata,
  input  logic                         sample_tick,
  input  logic [CHANNELS*SAMPLE_W-1:0] ch_sample_l,
  input  logic [CHANNELS*SAMPLE_W-1:0] ch_sample_r,
  output logic [OUT_W-1:0]             sample_l,
  output logic [OUT_W-1:0]             sample_r,
  output logic                         sample_valid,
  output logic                         busy
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W  = SAMPLE_W + VOL_W + $clog2(CHANNELS) + 1;
  localparam int PROD_W = ACC_W + VOL_W;

  localparam logic [CH_W-1:0]          CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic signed [PROD_W-1:0] OUT_MAX = PROD_W'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] OUT_MIN = ~OUT_MAX;

  logic [CHANNELS*8-1:0] ch_vol;
  logic [7:0]            master_vol;
  logic                  set_clip_l, set_clip_r, set_overrun;

  mix_state_t              state;
  logic [CH_W-1:0]         ch;
  logic signed [ACC_W-1:0] acc_l, acc_r;

  logic signed [SAMPLE_W-1:0] snap_l   [CHANNELS];
  logic signed [SAMPLE_W-1:0] snap_r   [CHANNELS];
  logic [7:0]                 snap_vol [CHANNELS];
  logic [7:0]                 snap_master;

  logic signed [ACC_W-1:0]  term_l, term_r;
  logic signed [PROD_W-1:0] mp_l, mp_r, m_l, m_r;
  logic [OUT_W-1:0]         sat_l, sat_r;
  logic                     clip_l, clip_r;

  sound_mixer_regs #(.CHANNELS(CHANNELS)) u_regs (
    .clk          (clk),
    .rst_n        (rst_n),
    .io_address   (io_address),
    .io_read      (io_read),
    .io_write     (io_write),
    .io_writedata (io_writedata),
    .io_readdata  (io_readdata),
    .ch_vol       (ch_vol),
    .master_vol   (master_vol),
    .set_clip_l   (set_clip_l),
    .set_clip_r   (set_clip_r),
    .set_overrun  (set_overrun)
  );

  // Snapshot sources and volumes when a mix starts, so later writes only affect the next mix.
  always_ff @(posedge clk) begin
    // NOTE: these holding registers are always loaded before they are read,
    // so they carry no reset.
    if (state == ST_IDLE && sample_tick) begin
      for (int c = 0; c < CHANNELS; c++) begin
        snap_l[c]   <= ch_sample_l[c*SAMPLE_W +: SAMPLE_W];
        snap_r[c]   <= ch_sample_r[c*SAMPLE_W +: SAMPLE_W];
        snap_vol[c] <= ch_vol[c*8 +: 8];
      end
      snap_master <= master_vol;
    end
  end

  // Per-channel term (signed sample times zero-extended gain) and master scaling.
  assign term_l = ACC_W'(snap_l[ch]) * ACC_W'($signed({1'b0, snap_vol[ch][7:4]}));
  assign term_r = ACC_W'(snap_r[ch]) * ACC_W'($signed({1'b0, snap_vol[ch][3:0]}));
  assign mp_l   = PROD_W'(acc_l) * PROD_W'($signed({1'b0, snap_master[7:4]}));
  assign mp_r   = PROD_W'(acc_r) * PROD_W'($signed({1'b0, snap_master[3:0]}));
  assign m_l    = mp_l >>> 8;
  assign m_r    = mp_r >>> 8;

  // Clamp the scaled sums to the output range and flag clipping.
  always_comb begin
    clip_l = (m_l > OUT_MAX) || (m_l < OUT_MIN);
    clip_r = (m_r > OUT_MAX) || (m_r < OUT_MIN);
    sat_l  = m_l[OUT_W-1:0];
    sat_r  = m_r[OUT_W-1:0];
    if (m_l > OUT_MAX) sat_l = OUT_MAX[OUT_W-1:0];
    if (m_l < OUT_MIN) sat_l = OUT_MIN[OUT_W-1:0];
    if (m_r > OUT_MAX) sat_r = OUT_MAX[OUT_W-1:0];
    if (m_r < OUT_MIN) sat_r = OUT_MIN[OUT_W-1:0];
  end

  assign set_clip_l  = (state == ST_MASTER) && clip_l;
  assign set_clip_r  = (state == ST_MASTER) && clip_r;
  assign set_overrun = sample_tick && (state != ST_IDLE);

  // Mix sequencer: IDLE -> ACC (one channel per clock) -> MASTER -> SAT -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ch           <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sample_tick) begin
            acc_l <= '0;
            acc_r <= '0;
            ch    <= '0;
            busy  <= 1'b1;
            state <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc_l <= acc_l + term_l;
          acc_r <= acc_r + term_r;
          if (ch == CH_LAST) state <= ST_MASTER;
          else               ch    <= ch + 1'b1;
        end
        ST_MASTER: begin
          // The saturated result is registered here so it is visible during SAT.
          sample_l     <= sat_l;
          sample_r     <= sat_r;
          sample_valid <= 1'b1;
          state        <= ST_SAT;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sound_mixer_mc.sv
// Self-checking bench for sound_mixer_mc: directed cases plus randomized
// mixes compared against an arithmetic reference model.
module tb_sound_mixer_mc;

  localparam int CH = 4;
  localparam int SW = 16;
  localparam int OW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             io_address = 1'b0;
  logic             io_read = 1'b0;
  logic             io_write = 1'b0;
  logic [7:0]       io_writedata = 8'h00;
  logic [7:0]       io_readdata;
  logic             sample_tick = 1'b0;
  logic [CH*SW-1:0] ch_sample_l, ch_sample_r;
  logic [OW-1:0]    sample_l, sample_r;
  logic             sample_valid, busy;

  logic signed [SW-1:0] s_l [CH];
  logic signed [SW-1:0] s_r [CH];

  // Reference model state
  logic [7:0] m_vol [CH];
  logic [7:0] m_master;
  logic [2:0] m_status;
  logic [7:0] m_index;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    ch_sample_l = '0;
    ch_sample_r = '0;
    for (int c = 0; c < CH; c++) begin
      ch_sample_l[c*SW +: SW] = s_l[c];
      ch_sample_r[c*SW +: SW] = s_r[c];
    end
  end

  sound_mixer_mc #(.CHANNELS(CH), .SAMPLE_W(SW), .OUT_W(OW), .VOL_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .io_address   (io_address),
    .io_read      (io_read),
    .io_write     (io_write),
    .io_writedata (io_writedata),
    .io_readdata  (io_readdata),
    .sample_tick  (sample_tick),
    .ch_sample_l  (ch_sample_l),
    .ch_sample_r  (ch_sample_r),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_defaults();
    for (int c = 0; c < CH; c++) m_vol[c] = 8'hFF;
    m_master = 8'hFF;
  endtask

  function automatic longint floor_div256(input longint v);
    if (v >= 0) return v / 256;
    return -((-v + 255) / 256);
  endfunction

  function automatic int clamp16(input longint v, output bit clipped);
    clipped = (v > 32767) || (v < -32768);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Expected mix from the current model volumes and the driven samples.
  task automatic model_mix(output int el, output int er, output bit cl, output bit cr);
    longint sl = 0, sr = 0;
    for (int c = 0; c < CH; c++) begin
      sl += longint'(s_l[c]) * longint'(m_vol[c][7:4]);
      sr += longint'(s_r[c]) * longint'(m_vol[c][3:0]);
    end
    sl = floor_div256(sl * longint'(m_master[7:4]));
    sr = floor_div256(sr * longint'(m_master[3:0]));
    el = clamp16(sl, cl);
    er = clamp16(sr, cr);
  endtask

  task automatic model_write(input logic [7:0] idx, input logic [7:0] val);
    if (idx == 8'h00) begin
      model_defaults();
      m_status = 3'b000;
    end else if (idx == 8'h22) begin
      m_master = val;
    end else begin
      for (int c = 0; c < CH; c++)
        if (idx == 8'h30 + 8'(c)) m_vol[c] = val;
    end
  endtask

  // One bus cycle, entered just after a rising edge.
  task automatic io_cycle(input logic addr, input logic [7:0] data);
    io_address   = addr;
    io_write     = 1'b1;
    io_writedata = data;
    @(posedge clk); #1;
    io_write = 1'b0;
  endtask

  task automatic reg_write(input logic [7:0] idx, input logic [7:0] val);
    io_cycle(1'b0, idx);
    io_cycle(1'b1, val);
    m_index = idx;
    model_write(idx, val);
  endtask

  task automatic read_check(input string tag, input logic [7:0] idx, input logic [7:0] exp);
    io_cycle(1'b0, idx);
    m_index    = idx;
    io_address = 1'b1;
    io_read    = 1'b1;
    @(negedge clk);
    check(tag, {24'h0, io_readdata}, {24'h0, exp});
    @(posedge clk); #1;
    io_read = 1'b0;
  endtask

  task automatic read_status(input string tag);
    read_check(tag, 8'h3F, {5'b0, m_status});
    m_status = 3'b000;
  endtask

  // Run one mix. tick2_at / wr_at / rst_at are cycle offsets after the tick (0 = unused).
  task automatic run_mix(input string tag, input int tick2_at, input int wr_at,
                         input logic [7:0] wr_val, input int rst_at);
    int el, er, valid_cnt, valid_k;
    bit cl, cr;
    logic [OW-1:0] got_l, got_r;
    logic [15:0] busy_obs, busy_exp;
    model_mix(el, er, cl, cr);
    valid_cnt = 0;
    valid_k   = 0;
    got_l     = '0;
    got_r     = '0;
    busy_obs  = '0;
    busy_exp  = '0;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    for (int k = 1; k <= CH + 3; k++) begin
      sample_tick = (k == tick2_at);
      if (k == wr_at) begin
        io_address   = 1'b1;
        io_write     = 1'b1;
        io_writedata = wr_val;
      end
      if (k == rst_at) rst_n = 1'b0;
      if (rst_at != 0 && k == rst_at + 1) rst_n = 1'b1;
      @(negedge clk);
      busy_obs[k] = busy;
      busy_exp[k] = (k <= CH + 2) && (rst_at == 0 || k < rst_at);
      if (sample_valid) begin
        valid_cnt++;
        valid_k = k;
        got_l   = sample_l;
        got_r   = sample_r;
      end
      @(posedge clk); #1;
      sample_tick = 1'b0;
      io_write    = 1'b0;
    end
    check({tag, "_busy"}, {16'h0, busy_obs}, {16'h0, busy_exp});
    if (rst_at == 0) begin
      check({tag, "_nvalid"}, valid_cnt, 1);
      check({tag, "_latency"}, valid_k, CH + 2);
      check({tag, "_l"}, {16'h0, got_l}, {16'h0, el[15:0]});
      check({tag, "_r"}, {16'h0, got_r}, {16'h0, er[15:0]});
      m_status = m_status | {1'b0, cr, cl};
      if (tick2_at != 0) m_status[2] = 1'b1;
      if (wr_at != 0) model_write(m_index, wr_val);
    end else begin
      check({tag, "_nvalid"}, valid_cnt, 0);
      check({tag, "_l_rst"}, {16'h0, sample_l}, 32'h0);
      check({tag, "_r_rst"}, {16'h0, sample_r}, 32'h0);
      model_defaults();
      m_status = 3'b000;
      m_index  = 8'h00;
    end
  endtask

  task automatic clear_samples();
    for (int c = 0; c < CH; c++) begin
      s_l[c] = '0;
      s_r[c] = '0;
    end
  endtask

  initial begin
    clear_samples();
    model_defaults();
    m_status = 3'b000;
    m_index  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    @(negedge clk);
    check("rst_sample_l", {16'h0, sample_l}, 32'h0);
    check("rst_sample_r", {16'h0, sample_r}, 32'h0);
    check("rst_valid", {31'h0, sample_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    io_address = 1'b0;
    #1;
    check("rst_index", {24'h0, io_readdata}, 32'h0);
    @(posedge clk); #1;
    read_check("rst_master", 8'h22, 8'hFF);
    read_check("rst_ch0", 8'h30, 8'hFF);
    read_check("rd_idx00", 8'h00, 8'h00);
    read_status("rst_status");

    // Single positive source, default volumes: 0x1000 -> 3600
    s_l[0] = 16'h1000;
    run_mix("t1", 0, 0, 8'h00, 0);
    read_status("t1_status");

    // Negative source exercises the arithmetic shift: -4096 -> -3600
    s_l[0] = 16'hF000;
    run_mix("t2", 0, 0, 8'h00, 0);

    // Full-scale on every channel clips both sides
    for (int c = 0; c < CH; c++) begin
      s_l[c] = 16'h7FFF;
      s_r[c] = 16'h7FFF;
    end
    run_mix("t3", 0, 0, 8'h00, 0);
    read_status("t3_status1");
    read_status("t3_status2");

    // Left muted on channel 0, then restored by the reset index
    clear_samples();
    reg_write(8'h30, 8'h0F);
    reg_write(8'h22, 8'hFF);
    read_check("t4_rdvol", 8'h30, 8'h0F);
    s_l[0] = 16'h1000;
    s_r[0] = 16'h1000;
    run_mix("t4a", 0, 0, 8'h00, 0);
    reg_write(8'h00, 8'h5A);
    run_mix("t4b", 0, 0, 8'h00, 0);

    // Tick while busy plus a mid-mix volume write
    io_cycle(1'b0, 8'h30);
    m_index = 8'h30;
    run_mix("t5", 3, 2, 8'h00, 0);
    read_status("t5_status");
    read_check("t5_vol", 8'h30, 8'h00);
    run_mix("t5m", 0, 0, 8'h00, 0);
    reg_write(8'h30, 8'hFF);
    run_mix("t5sat", CH + 2, 0, 8'h00, 0);
    read_status("t5sat_status");

    // Reset in the middle of a mix
    reg_write(8'h22, 8'h77);
    run_mix("t6", 0, 0, 8'h00, 3);
    read_check("t6_master", 8'h22, 8'hFF);
    read_check("t6_idx50", 8'h50, 8'hFF);
    read_status("t6_status");

    // Randomized mixes against the reference model
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CH; c++) begin
        s_l[c] = SW'($urandom);
        s_r[c] = SW'($urandom);
        reg_write(8'h30 + 8'(c), 8'($urandom));
      end
      reg_write(8'h22, 8'($urandom));
      run_mix($sformatf("rnd%0d", i), 0, 0, 8'h00, 0);
      read_status($sformatf("rnd%0d_status", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
